// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, funct3 codes, ALU operation
// encoding and the decoded-instruction payload carried from decode to execute.
package decode_pkg;

  // Major opcodes (inst[6:0]).
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct7 values that select the base or the alternate (SUB/SRA) operation.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 codes for ALU operations.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  // Everything execute needs about one instruction, pc excluded.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    alu_op_e     alu_op;
    logic        op_a_pc;
    logic        op_b_imm;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        rf_we;
    logic        illegal;
  } decoded_t;

  // Map funct3 to an ALU op; alt selects SUB/SRA over ADD/SRL.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: alu_from_funct3 = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     alu_from_funct3 = ALU_SLL;
      F3_SLT:     alu_from_funct3 = ALU_SLT;
      F3_SLTU:    alu_from_funct3 = ALU_SLTU;
      F3_XOR:     alu_from_funct3 = ALU_XOR;
      F3_SRL_SRA: alu_from_funct3 = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      alu_from_funct3 = ALU_OR;
      default:    alu_from_funct3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I decoder: instruction word -> register indices,
// immediate, ALU control, class flags and illegal-instruction detection.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] inst_i,
  output decoded_t    dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i_fmt;
  logic [31:0] imm_s_fmt;
  logic [31:0] imm_b_fmt;
  logic [31:0] imm_u_fmt;
  logic [31:0] imm_j_fmt;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  assign imm_i_fmt = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s_fmt = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_fmt = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_fmt = {inst_i[31:12], 12'b0};
  assign imm_j_fmt = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // Decode the opcode class, then squash side effects of illegal or rd=x0 instructions.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    dec_o        = '0;
    dec_o.rs1    = inst_i[19:15];
    dec_o.rs2    = inst_i[24:20];
    dec_o.rd     = inst_i[11:7];
    dec_o.funct3 = funct3;
    dec_o.alu_op = ALU_ADD;

    if (inst_i[1:0] != 2'b11) begin
      dec_o.illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          dec_o.imm      = imm_u_fmt;
          dec_o.alu_op   = ALU_PASS_B;
          dec_o.op_b_imm = 1'b1;
          dec_o.rf_we    = 1'b1;
        end
        OPC_AUIPC: begin
          dec_o.imm      = imm_u_fmt;
          dec_o.op_a_pc  = 1'b1;
          dec_o.op_b_imm = 1'b1;
          dec_o.rf_we    = 1'b1;
        end
        OPC_JAL: begin
          dec_o.imm      = imm_j_fmt;
          dec_o.op_a_pc  = 1'b1;
          dec_o.op_b_imm = 1'b1;
          dec_o.is_jal   = 1'b1;
          dec_o.rf_we    = 1'b1;
        end
        OPC_JALR: begin
          dec_o.imm      = imm_i_fmt;
          dec_o.op_b_imm = 1'b1;
          dec_o.is_jalr  = 1'b1;
          dec_o.rf_we    = 1'b1;
          dec_o.illegal  = (funct3 != 3'b000);
        end
        OPC_BRANCH: begin
          dec_o.imm       = imm_b_fmt;
          dec_o.alu_op    = ALU_SUB;
          dec_o.is_branch = 1'b1;
          dec_o.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
        end
        OPC_LOAD: begin
          dec_o.imm      = imm_i_fmt;
          dec_o.op_b_imm = 1'b1;
          dec_o.is_load  = 1'b1;
          dec_o.rf_we    = 1'b1;
          dec_o.illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        OPC_STORE: begin
          dec_o.imm      = imm_s_fmt;
          dec_o.op_b_imm = 1'b1;
          dec_o.is_store = 1'b1;
          dec_o.illegal  = (funct3 >= 3'b011);
        end
        OPC_OP_IMM: begin
          dec_o.imm      = imm_i_fmt;
          dec_o.op_b_imm = 1'b1;
          dec_o.rf_we    = 1'b1;
          // Only the right-shift form uses inst[30] as an operation selector;
          // ADDI with a negative immediate must stay ADD.
          dec_o.alu_op   = alu_from_funct3(funct3, (funct3 == F3_SRL_SRA) && inst_i[30]);
          if (funct3 == F3_SLL)
            dec_o.illegal = (funct7 != F7_BASE);
          else if (funct3 == F3_SRL_SRA)
            dec_o.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        end
        OPC_OP: begin
          dec_o.rf_we = 1'b1;
          if (funct7 == F7_BASE)
            dec_o.alu_op = alu_from_funct3(funct3, 1'b0);
          else if ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)))
            dec_o.alu_op = alu_from_funct3(funct3, 1'b1);
          else
            dec_o.illegal = 1'b1;
        end
        OPC_MISC_MEM: begin
          // FENCE has no effect in this in-order pipeline: pass through as a NOP.
          dec_o.imm = imm_i_fmt;
        end
        OPC_SYSTEM: begin
          dec_o.imm     = imm_i_fmt;
          dec_o.illegal = 1'b1;
        end
        default: dec_o.illegal = 1'b1;
      endcase
    end

    if (dec_o.illegal) begin
      dec_o.is_load   = 1'b0;
      dec_o.is_store  = 1'b0;
      dec_o.is_branch = 1'b0;
      dec_o.is_jal    = 1'b0;
      dec_o.is_jalr   = 1'b0;
      dec_o.rf_we     = 1'b0;
    end
    if (dec_o.rd == 5'd0)
      dec_o.rf_we = 1'b0;
  end

endmodule

// File: rtl/decode.sv
// Decode pipeline stage: wraps decode_comb with a valid/ready output register
// that stalls on execute back-pressure and drops its instruction on a flush.
module decode
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     inst_i,
  output logic            valid_ro,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_ro,
  output logic [4:0]      rs1_ro,
  output logic [4:0]      rs2_ro,
  output logic [4:0]      rd_ro,
  output logic [XLEN-1:0] imm_ro,
  output logic [2:0]      funct3_ro,
  output logic [3:0]      alu_op_ro,
  output logic            op_a_pc_ro,
  output logic            op_b_imm_ro,
  output logic            is_load_ro,
  output logic            is_store_ro,
  output logic            is_branch_ro,
  output logic            is_jal_ro,
  output logic            is_jalr_ro,
  output logic            rf_we_ro,
  output logic            illegal_ro
);

  logic            cke;
  logic            load_payload;
  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q;
  decoded_t        dec_d, dec_q;

  decode_comb u_decode_comb (
    .inst_i (inst_i),
    .dec_o  (dec_d)
  );

  // The stage advances whenever it is empty or execute is taking its contents.
  assign cke          = ~valid_q | ready_i;
  assign ready_o      = cke;
  assign load_payload = cke & valid_i;
  assign pc_d         = pc_i;

  // Next valid: a flush wins over everything, otherwise follow upstream when enabled.
  always_comb begin
    valid_d = valid_q;
    if (flush_i)
      valid_d = 1'b0;
    else if (cke)
      valid_d = valid_i;
  end

  // Valid flag register; reset leaves the stage empty.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n)
      valid_q <= 1'b0;
    else
      valid_q <= valid_d;
  end

  // Payload register; loads only for real instructions so bubbles leave it quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      dec_q <= '0;
    end else if (load_payload) begin
      pc_q  <= pc_d;
      dec_q <= dec_d;
    end
  end

  assign valid_ro     = valid_q;
  assign pc_ro        = pc_q;
  assign rs1_ro       = dec_q.rs1;
  assign rs2_ro       = dec_q.rs2;
  assign rd_ro        = dec_q.rd;
  assign imm_ro       = dec_q.imm;
  assign funct3_ro    = dec_q.funct3;
  assign alu_op_ro    = dec_q.alu_op;
  assign op_a_pc_ro   = dec_q.op_a_pc;
  assign op_b_imm_ro  = dec_q.op_b_imm;
  assign is_load_ro   = dec_q.is_load;
  assign is_store_ro  = dec_q.is_store;
  assign is_branch_ro = dec_q.is_branch;
  assign is_jal_ro    = dec_q.is_jal;
  assign is_jalr_ro   = dec_q.is_jalr;
  assign rf_we_ro     = dec_q.rf_we;
  assign illegal_ro   = dec_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed testbench for the decode stage: hand-decoded RV32I vectors,
// stall/flush/bubble handshake behaviour and reset in the middle of a stall.
module tb_decode;

  // Expected ALU codes, written out independently of the design package.
  localparam logic [3:0] E_ADD    = 4'd0;
  localparam logic [3:0] E_SUB    = 4'd1;
  localparam logic [3:0] E_SRA    = 4'd7;
  localparam logic [3:0] E_PASS_B = 4'd10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        valid_ro;
  logic        ready_i;
  logic [31:0] pc_ro;
  logic [4:0]  rs1_ro, rs2_ro, rd_ro;
  logic [31:0] imm_ro;
  logic [2:0]  funct3_ro;
  logic [3:0]  alu_op_ro;
  logic        op_a_pc_ro, op_b_imm_ro;
  logic        is_load_ro, is_store_ro, is_branch_ro, is_jal_ro, is_jalr_ro;
  logic        rf_we_ro, illegal_ro;

  int n_assert = 0;
  int n_fail   = 0;

  decode #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .valid_ro     (valid_ro),
    .ready_i      (ready_i),
    .pc_ro        (pc_ro),
    .rs1_ro       (rs1_ro),
    .rs2_ro       (rs2_ro),
    .rd_ro        (rd_ro),
    .imm_ro       (imm_ro),
    .funct3_ro    (funct3_ro),
    .alu_op_ro    (alu_op_ro),
    .op_a_pc_ro   (op_a_pc_ro),
    .op_b_imm_ro  (op_b_imm_ro),
    .is_load_ro   (is_load_ro),
    .is_store_ro  (is_store_ro),
    .is_branch_ro (is_branch_ro),
    .is_jal_ro    (is_jal_ro),
    .is_jalr_ro   (is_jalr_ro),
    .rf_we_ro     (rf_we_ro),
    .illegal_ro   (illegal_ro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    valid_i = v;
    pc_i    = pc;
    inst_i  = inst;
  endtask

  initial begin
    rst_n   = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk("rst_valid",   32'(valid_ro),   32'd0);
    chk("rst_illegal", 32'(illegal_ro), 32'd0);
    chk("rst_rf_we",   32'(rf_we_ro),   32'd0);
    chk("rst_imm",     imm_ro,          32'h0);
    chk("rst_pc",      pc_ro,           32'h0);
    chk("rst_ready",   32'(ready_o),    32'd1);
    #9 rst_n = 1'b1;
    step();

    // addi x1,x0,-1
    drive(1'b1, 32'h0000_0000, 32'hFFF0_0093);
    chk("addi_not_yet", 32'(valid_ro), 32'd0);
    step();
    chk("addi_valid",    32'(valid_ro),    32'd1);
    chk("addi_rd",       32'(rd_ro),       32'd1);
    chk("addi_rs1",      32'(rs1_ro),      32'd0);
    chk("addi_imm",      imm_ro,           32'hFFFF_FFFF);
    chk("addi_alu",      32'(alu_op_ro),   32'(E_ADD));
    chk("addi_op_b_imm", 32'(op_b_imm_ro), 32'd1);
    chk("addi_op_a_pc",  32'(op_a_pc_ro),  32'd0);
    chk("addi_rf_we",    32'(rf_we_ro),    32'd1);

    // beq x1,x2,-4 at pc 0x100
    drive(1'b1, 32'h0000_0100, 32'hFE20_8EE3);
    step();
    chk("beq_pc",     pc_ro,            32'h0000_0100);
    chk("beq_rs1",    32'(rs1_ro),      32'd1);
    chk("beq_rs2",    32'(rs2_ro),      32'd2);
    chk("beq_imm",    imm_ro,           32'hFFFF_FFFC);
    chk("beq_branch", 32'(is_branch_ro), 32'd1);
    chk("beq_alu",    32'(alu_op_ro),   32'(E_SUB));
    chk("beq_rf_we",  32'(rf_we_ro),    32'd0);

    // lui x5,0x12345
    drive(1'b1, 32'h0000_0104, 32'h1234_52B7);
    step();
    chk("lui_imm",   imm_ro,          32'h1234_5000);
    chk("lui_alu",   32'(alu_op_ro),  32'(E_PASS_B));
    chk("lui_rd",    32'(rd_ro),      32'd5);
    chk("lui_rf_we", 32'(rf_we_ro),   32'd1);

    // Stall three cycles with a changing instruction stream: lui must stay put.
    ready_i = 1'b0;
    #1;
    chk("stall_ready", 32'(ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4), 32'hFFF0_0093 + 32'(i << 7));
      step();
      chk("stall_valid", 32'(valid_ro), 32'd1);
      chk("stall_imm",   imm_ro,        32'h1234_5000);
      chk("stall_rd",    32'(rd_ro),    32'd5);
      chk("stall_pc",    pc_ro,         32'h0000_0104);
    end
    // add x3,x1,x2 presented as the stall ends.
    drive(1'b1, 32'h0000_0300, 32'h0020_81B3);
    ready_i = 1'b1;
    #1;
    chk("unstall_ready", 32'(ready_o), 32'd1);
    step();
    chk("add_rd",       32'(rd_ro),       32'd3);
    chk("add_pc",       pc_ro,            32'h0000_0300);
    chk("add_alu",      32'(alu_op_ro),   32'(E_ADD));
    chk("add_op_b_imm", 32'(op_b_imm_ro), 32'd0);
    chk("add_imm",      imm_ro,           32'h0);
    chk("add_rf_we",    32'(rf_we_ro),    32'd1);

    // sub x3,x1,x2
    drive(1'b1, 32'h0000_0304, 32'h4020_81B3);
    step();
    chk("sub_alu", 32'(alu_op_ro), 32'(E_SUB));

    // srai x4,x1,3
    drive(1'b1, 32'h0000_0308, 32'h4030_D213);
    step();
    chk("srai_alu",     32'(alu_op_ro),  32'(E_SRA));
    chk("srai_illegal", 32'(illegal_ro), 32'd0);

    // slli with funct7=0100000 is illegal but still propagates.
    drive(1'b1, 32'h0000_030C, 32'h4030_9213);
    step();
    chk("slli_bad_illegal", 32'(illegal_ro), 32'd1);
    chk("slli_bad_valid",   32'(valid_ro),   32'd1);
    chk("slli_bad_rf_we",   32'(rf_we_ro),   32'd0);

    // lw x1,4(x2)
    drive(1'b1, 32'h0000_0310, 32'h0041_2083);
    step();
    chk("lw_load",   32'(is_load_ro), 32'd1);
    chk("lw_imm",    imm_ro,          32'h0000_0004);
    chk("lw_funct3", 32'(funct3_ro),  32'd2);
    chk("lw_rf_we",  32'(rf_we_ro),   32'd1);

    // Flush during a stall empties the stage on the next edge.
    ready_i = 1'b0;
    flush_i = 1'b1;
    drive(1'b1, 32'h0000_0400, 32'h0010_0093);
    step();
    chk("flush_valid", 32'(valid_ro), 32'd0);
    flush_i = 1'b0;
    ready_i = 1'b1;

    // All-zero word is illegal: valid, no write, no class flags.
    drive(1'b1, 32'h0000_0500, 32'h0000_0000);
    step();
    chk("zero_valid",   32'(valid_ro),    32'd1);
    chk("zero_illegal", 32'(illegal_ro),  32'd1);
    chk("zero_rf_we",   32'(rf_we_ro),    32'd0);
    chk("zero_flags",   32'({is_load_ro, is_store_ro, is_branch_ro, is_jal_ro, is_jalr_ro}), 32'd0);

    // ld (funct3 011) is not RV32I.
    drive(1'b1, 32'h0000_0504, 32'h0000_B083);
    step();
    chk("ld_illegal", 32'(illegal_ro), 32'd1);
    chk("ld_load",    32'(is_load_ro), 32'd0);

    // addi x0,x0,1: legal but rd=x0 suppresses the write.
    drive(1'b1, 32'h0000_0508, 32'h0010_0013);
    step();
    chk("x0_illegal", 32'(illegal_ro), 32'd0);
    chk("x0_rf_we",   32'(rf_we_ro),   32'd0);
    chk("x0_imm",     imm_ro,          32'h0000_0001);

    // A bubble clears valid but leaves the payload untouched.
    drive(1'b0, 32'h0000_0600, 32'h1234_52B7);
    step();
    chk("bubble_valid", 32'(valid_ro), 32'd0);
    chk("bubble_imm",   imm_ro,        32'h0000_0001);
    chk("bubble_pc",    pc_ro,         32'h0000_0508);

    // Load lui, stall on it, then pulse reset mid-stall.
    drive(1'b1, 32'h0000_0700, 32'h1234_52B7);
    step();
    chk("pre_rst_valid", 32'(valid_ro), 32'd1);
    ready_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_ro), 32'd0);
    chk("midrst_imm",   imm_ro,        32'h0);
    chk("midrst_ready", 32'(ready_o),  32'd1);
    drive(1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    step();
    chk("postrst_ready", 32'(ready_o),  32'd1);
    chk("postrst_valid", 32'(valid_ro), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported (RV32I).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush_i  input  1  kill in-flight instruction (branch redirect from execute).
REQ-005 valid_i  input  1  upstream (fetch) instruction valid.
REQ-006 ready_o  output  1  decode can accept this cycle.
REQ-007 pc_i  input  32  instruction address.
REQ-008 inst_i  input  32  raw instruction word.
REQ-009 valid_ro  output  1  registered decoded-instruction valid, to execute.
REQ-010 ready_i  input  1  execute can accept.
REQ-011 pc_ro  output  32  registered pc.
REQ-012 rs1_ro, rs2_ro, rd_ro  output  5 each  register indices.
REQ-013 imm_ro  output  32  sign-extended immediate.
REQ-014 funct3_ro  output  3  raw funct3.
REQ-015 alu_op_ro  output  4  ALU operation code (package enum).
REQ-016 op_a_pc_ro / op_b_imm_ro  output  1 each  ALU operand A = pc, operand B = imm.
REQ-017 is_load_ro, is_store_ro, is_branch_ro, is_jal_ro, is_jalr_ro  output  1 each  class flags.
REQ-018 rf_we_ro  output  1  register-file write enable.
REQ-019 illegal_ro  output  1  illegal-instruction flag.

Function
REQ-020 Internal enable cke = ~valid_ro | ready_i; ready_o SHALL equal cke combinationally.
REQ-021 On a rising edge with flush_i=1, valid_ro SHALL become 0 regardless of cke; the payload is don't-care.
REQ-022 Otherwise, when cke=1, valid_ro SHALL load valid_i and every payload register SHALL load the decode of pc_i/inst_i; latency is one cycle.
REQ-023 When cke=0 (valid_ro=1, ready_i=0), all outputs SHALL hold their values unchanged.
REQ-024 Payload registers SHALL update only when cke=1 and valid_i=1 (bubbles do not toggle the payload).
REQ-025 Immediate formats: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U = {inst[31:12],12'b0}; J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); R-type imm = 0.
REQ-026 Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (FENCE treated as NOP), SYSTEM (ECALL/EBREAK flagged illegal for this revision).
REQ-027 alu_op: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B (LUI); loads, stores, AUIPC, JAL, JALR use ADD; branches use SUB (funct3 selects the compare in execute).
REQ-028 rf_we SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, and SHALL be forced 0 when rd=0 or illegal=1.
REQ-029 illegal SHALL be 1 for: inst[1:0]!=2'b11; unknown opcode; OP with funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101}; shift-immediate with inst[31:25] not in {0000000, 0100000 (SRAI only)}; JALR funct3!=0; LOAD funct3 in {011, 110, 111}; STORE funct3>=011; BRANCH funct3 in {010, 011}; SYSTEM.
REQ-030 An illegal instruction SHALL still propagate with valid_ro=1 and all class flags 0.

Reset
REQ-031 While rst_n=0: valid_ro=0, illegal_ro=0, rf_we_ro=0, all class flags 0, all other payload outputs 0; asynchronous assertion, synchronous-safe deassertion.
REQ-032 Reset mid-stall SHALL discard the held instruction; ready_o SHALL be 1 in the first cycle after reset.

Structure
REQ-033 Shared package: opcode localparams, alu_op enum, funct3 codes; execute imports the same package.
REQ-034 One combinational sub-module, decode_comb (inst -> fields, imm, flags, illegal); decode wraps it with the handshake register.

Verification
REQ-035 addi x1,x0,-1 (0xFFF00093) -> rd=1, rs1=0, imm=0xFFFFFFFF, alu=ADD, op_b_imm=1, rf_we=1, one cycle later.
REQ-036 beq x1,x2,-4 (0xFE208EE3) at pc 0x100 -> rs1=1, rs2=2, imm=0xFFFFFFFC, is_branch=1, alu=SUB, rf_we=0.
REQ-037 lui x5,0x12345 (0x123452B7) -> imm=0x12345000, alu=PASS_B, rd=5, rf_we=1.
REQ-038 valid_ro=1 with ready_i=0 for 3 cycles while inst_i changes -> ready_o=0, outputs frozen; ready_i=1 -> next instruction loaded the following edge.
REQ-039 flush_i=1 during the stall -> valid_ro=0 next edge; 0x00000000 -> illegal_ro=1, rf_we=0.
REQ-040 rst_n pulsed low mid-stall -> valid_ro=0 immediately, ready_o=1 after release.
